ctl_game: RTL and testbench

CTL_GAME -- requirements
Module: ctl_game

---
 rtl/dh_pkg.sv | 25 ++
 rtl/ctl_game_if.sv | 33 +++
 rtl/bcd_counter2.sv | 63 ++++++
 rtl/ctl_game.sv | 133 +++++++++++++
 tb/tb_ctl_game.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/dh_pkg.sv
// Shared types and defaults for the duck-hunt game controller.
package dh_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_LAST_SHOT = 2'd2,
        ST_OVER      = 2'd3
    } game_state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam int DEF_START_AMMO     = 15;
    localparam int DEF_RESOLVE_FRAMES = 4;

    // Convert a small integer (clamped to 0..99) into two packed BCD digits.
    function automatic logic [7:0] to_bcd2(input int value);
        int v;
        v = value;
        if (v > 99) v = 99;
        if (v < 0)  v = 0;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/ctl_game_if.sv
// Game event inputs, display/status outputs and a state debug tap.
// Every signal is a level sampled on the rising clock edge; the event
// inputs are one-cycle pulses and the outputs change only after an edge.
interface ctl_game_if;
    import dh_pkg::*;

    logic        start;
    logic        new_frame;
    logic        shot_fired;
    logic        hit;
    logic        miss;
    logic        duck_kill;
    bcd_digit_t  score_tens;
    bcd_digit_t  score_ones;
    bcd_digit_t  ammo_tens;
    bcd_digit_t  ammo_ones;
    logic        playing;
    logic        game_over;
    game_state_e dbg_state;

    modport master (
        output start, new_frame, shot_fired, hit, miss,
        input  duck_kill, score_tens, score_ones, ammo_tens, ammo_ones,
        input  playing, game_over, dbg_state
    );

    modport slave (
        input  start, new_frame, shot_fired, hit, miss,
        output duck_kill, score_tens, score_ones, ammo_tens, ammo_ones,
        output playing, game_over, dbg_state
    );

endinterface

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter, 00..99, saturating in both directions.
// load wins over inc/dec; inc and dec together cancel out.
module bcd_counter2
    import dh_pkg::*;
#(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       inc,
    input  logic       dec,
    output bcd_digit_t tens,
    output bcd_digit_t ones
);

    bcd_digit_t tens_q, tens_d;
    bcd_digit_t ones_q, ones_d;
    logic       at_max;
    logic       at_min;

    // Next digit values: load, then increment with carry or decrement with borrow.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        at_max = (tens_q == 4'd9) && (ones_q == 4'd9);
        at_min = (tens_q == 4'd0) && (ones_q == 4'd0);
        if (load) begin
            tens_d = load_val[7:4];
            ones_d = load_val[3:0];
        end else if (inc && !dec && !at_max) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end else if (dec && !inc && !at_min) begin
            if (ones_q == 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
    end

    // Digit registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tens_q <= RST_VAL[7:4];
            ones_q <= RST_VAL[3:0];
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/ctl_game.sv
// Game controller: tracks score and ammo in BCD and sequences a round
// from start through the final shot's resolution to game over.
module ctl_game
    import dh_pkg::*;
#(
    parameter int START_AMMO     = DEF_START_AMMO,
    parameter int RESOLVE_FRAMES = DEF_RESOLVE_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    ctl_game_if.slave  bus
);

    localparam logic [7:0] AMMO_BCD = to_bcd2(START_AMMO);
    localparam logic [7:0] RF_LAST  = 8'(RESOLVE_FRAMES - 1);

    game_state_e state_q, state_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        duck_kill_q, duck_kill_d;
    logic        playing_q, playing_d;
    logic        game_over_q, game_over_d;

    logic        score_load, score_inc;
    logic        ammo_load, ammo_dec;
    bcd_digit_t  score_tens, score_ones;
    bcd_digit_t  ammo_tens, ammo_ones;
    logic        ammo_zero, ammo_one;

    assign ammo_zero = (ammo_tens == 4'd0) && (ammo_ones == 4'd0);
    assign ammo_one  = (ammo_tens == 4'd0) && (ammo_ones == 4'd1);

    // Next state, counter controls and registered-output next values.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        duck_kill_d = 1'b0;
        score_load  = 1'b0;
        score_inc   = 1'b0;
        ammo_load   = 1'b0;
        ammo_dec    = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    score_load  = 1'b1;
                    ammo_load   = 1'b1;
                    frame_cnt_d = 8'd0;
                    state_d     = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (bus.hit) begin
                    score_inc   = 1'b1;
                    duck_kill_d = 1'b1;
                end
                if (bus.shot_fired && !ammo_zero) begin
                    ammo_dec = 1'b1;
                    if (ammo_one) begin
                        state_d     = ST_LAST_SHOT;
                        frame_cnt_d = 8'd0;
                    end
                end
            end
            ST_LAST_SHOT: begin
                // The last shot's result ends the game; otherwise give up
                // after RESOLVE_FRAMES frames without a result.
                if (bus.hit) begin
                    score_inc   = 1'b1;
                    duck_kill_d = 1'b1;
                end
                if (bus.hit || bus.miss) begin
                    state_d = ST_OVER;
                end else if (bus.new_frame) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    if (frame_cnt_q >= RF_LAST) begin
                        state_d = ST_OVER;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        playing_d   = (state_d == ST_PLAY) || (state_d == ST_LAST_SHOT);
        game_over_d = (state_d == ST_OVER);
    end

    // State and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= 8'd0;
            duck_kill_q <= 1'b0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            duck_kill_q <= duck_kill_d;
            playing_q   <= playing_d;
            game_over_q <= game_over_d;
        end
    end

    bcd_counter2 #(.RST_VAL(8'h00)) u_score (
        .clk      (clk),
        .rst      (rst),
        .load     (score_load),
        .load_val (8'h00),
        .inc      (score_inc),
        .dec      (1'b0),
        .tens     (score_tens),
        .ones     (score_ones)
    );

    bcd_counter2 #(.RST_VAL(AMMO_BCD)) u_ammo (
        .clk      (clk),
        .rst      (rst),
        .load     (ammo_load),
        .load_val (AMMO_BCD),
        .inc      (1'b0),
        .dec      (ammo_dec),
        .tens     (ammo_tens),
        .ones     (ammo_ones)
    );

    assign bus.duck_kill  = duck_kill_q;
    assign bus.playing    = playing_q;
    assign bus.game_over  = game_over_q;
    assign bus.score_tens = score_tens;
    assign bus.score_ones = score_ones;
    assign bus.ammo_tens  = ammo_tens;
    assign bus.ammo_ones  = ammo_ones;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_ctl_game.sv
// Bench for ctl_game: per-cycle stimulus feeds a behavioural game model
// whose predicted outputs are queued and compared one cycle later.
module tb_ctl_game;

    localparam int START_AMMO     = 15;
    localparam int RESOLVE_FRAMES = 4;
    localparam int W              = 19;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ctl_game_if gif ();

    ctl_game #(
        .START_AMMO     (START_AMMO),
        .RESOLVE_FRAMES (RESOLVE_FRAMES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (gif)
    );

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_PLAY, M_RESOLVE, M_OVER} mode_e;
    mode_e m_mode   = M_IDLE;
    int    m_score  = 0;
    int    m_ammo   = START_AMMO;
    int    m_frames = 0;
    bit    m_kill   = 1'b0;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    string        phase = "reset";
    int           checks = 0;
    int           failures = 0;

    task automatic model_step(input bit r, input bit st, input bit nf,
                              input bit sf, input bit h, input bit m);
        m_kill = 1'b0;
        if (!r) begin
            m_mode   = M_IDLE;
            m_score  = 0;
            m_ammo   = START_AMMO;
            m_frames = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_OVER: begin
                    if (st) begin
                        m_score  = 0;
                        m_ammo   = START_AMMO;
                        m_frames = 0;
                        m_mode   = M_PLAY;
                    end
                end
                M_PLAY: begin
                    if (h) begin
                        m_score = (m_score < 99) ? m_score + 1 : 99;
                        m_kill  = 1'b1;
                    end
                    if (sf && m_ammo > 0) begin
                        m_ammo = m_ammo - 1;
                        if (m_ammo == 0) begin
                            m_mode   = M_RESOLVE;
                            m_frames = 0;
                        end
                    end
                end
                M_RESOLVE: begin
                    if (h) begin
                        m_score = (m_score < 99) ? m_score + 1 : 99;
                        m_kill  = 1'b1;
                    end
                    if (h || m) begin
                        m_mode = M_OVER;
                    end else if (nf) begin
                        m_frames = m_frames + 1;
                        if (m_frames >= RESOLVE_FRAMES) m_mode = M_OVER;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    function automatic logic [W-1:0] model_outputs();
        logic is_play;
        logic is_over;
        is_play = (m_mode == M_PLAY) || (m_mode == M_RESOLVE);
        is_over = (m_mode == M_OVER);
        return {m_kill, is_play, is_over,
                4'(m_score / 10), 4'(m_score % 10),
                4'(m_ammo / 10), 4'(m_ammo % 10)};
    endfunction

    // ---------------- driver ----------------
    task automatic drive_cycle(input bit r, input bit st, input bit nf,
                               input bit sf, input bit h, input bit m);
        @(negedge clk);
        rst            = r;
        gif.start      = st;
        gif.new_frame  = nf;
        gif.shot_fired = sf;
        gif.hit        = h;
        gif.miss       = m;
        model_step(r, st, nf, sf, h, m);
        exp_q.push_back(model_outputs());
        name_q.push_back(phase);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1, 0, 0, 0, 0, 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [W-1:0] act;
        logic [W-1:0] exp;
        string        nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {gif.duck_kill, gif.playing, gif.game_over,
                       gif.score_tens, gif.score_ones,
                       gif.ammo_tens, gif.ammo_ones};
                checks++;
                if (act !== exp) begin
                    failures++;
                    $display("FAIL %s: got kill/play/over/score/ammo=%b%b%b/%h/%h required %b%b%b/%h/%h",
                             nm, act[18], act[17], act[16], act[15:8], act[7:0],
                             exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        gif.start      = 1'b0;
        gif.new_frame  = 1'b0;
        gif.shot_fired = 1'b0;
        gif.hit        = 1'b0;
        gif.miss       = 1'b0;

        phase = "reset_state";
        repeat (3) drive_cycle(0, 0, 0, 0, 0, 0);

        phase = "start_game";
        drive_cycle(1, 1, 0, 0, 0, 0);
        idle(2);

        phase = "shots_with_misses";
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1, 0, 0, 1, 0, 0);
            idle(2);
            drive_cycle(1, 0, 0, 0, 0, 1);
        end
        idle(1);

        phase = "hits_to_09";
        for (int i = 0; i < 9; i++) drive_cycle(1, 0, 0, 0, 1, 0);
        phase = "hit_and_shot";
        drive_cycle(1, 0, 0, 1, 1, 0);
        idle(2);

        phase = "hit_and_miss";
        drive_cycle(1, 0, 0, 0, 1, 1);
        idle(1);

        phase = "empty_magazine";
        for (int i = 0; i < 8; i++) drive_cycle(1, 0, 0, 1, 0, 0);
        phase = "shot_in_last_shot";
        drive_cycle(1, 0, 0, 1, 0, 0);
        phase = "frame_timeout";
        for (int i = 0; i < RESOLVE_FRAMES; i++) begin
            idle(2);
            drive_cycle(1, 0, 1, 0, 0, 0);
        end
        idle(1);
        phase = "hit_after_over";
        drive_cycle(1, 0, 0, 0, 1, 0);
        drive_cycle(1, 0, 0, 1, 0, 1);
        idle(1);

        phase = "restart";
        drive_cycle(1, 1, 0, 0, 0, 0);
        phase = "start_ignored_in_play";
        drive_cycle(1, 0, 0, 1, 0, 0);
        drive_cycle(1, 1, 0, 0, 0, 0);
        phase = "score_to_99";
        for (int i = 0; i < 99; i++) drive_cycle(1, 0, 0, 0, 1, 0);
        phase = "score_saturate";
        drive_cycle(1, 0, 0, 0, 1, 0);
        drive_cycle(1, 0, 0, 0, 1, 0);
        idle(1);

        phase = "to_last_shot";
        for (int i = 0; i < START_AMMO - 1; i++) drive_cycle(1, 0, 0, 1, 0, 0);
        idle(1);
        phase = "reset_in_last_shot";
        drive_cycle(0, 0, 0, 0, 0, 0);
        idle(1);

        phase = "last_shot_hit";
        drive_cycle(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < START_AMMO; i++) drive_cycle(1, 0, 0, 1, 0, 0);
        drive_cycle(1, 0, 0, 0, 1, 0);
        idle(2);

        phase = "random";
        for (int i = 0; i < 4000; i++) begin
            drive_cycle(($urandom_range(0, 599) != 0),
                        ($urandom_range(0, 15) == 0),
                        ($urandom_range(0, 7) == 0),
                        ($urandom_range(0, 3) == 0),
                        ($urandom_range(0, 4) == 0),
                        ($urandom_range(0, 4) == 0));
        end
        idle(2);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
